// File: rtl/inst_queue_if.sv
// -----------------------------------------------------------------------------
// inst_queue_if
// Bundles the fetch-side, decode-side and ROB flush signals of the instruction
// queue so the queue and its neighbours connect through one port.
//   master : the fetch/decode/ROB side (drives pushes, pops and flushes)
//   slave  : the queue itself (reports full/empty and presents the head entry)
// Signals:
//   IF_valid, IF_inst[31:0], IF_pc[31:0]  fetch push request and payload
//   IF_queue_is_full                      queue holds DEPTH entries
//   ID_enable                             decode consumes the head entry
//   ID_queue_is_empty                     queue holds no entries
//   ID_inst[31:0], ID_pc[31:0]            head entry (zero when empty)
//   ROB_clear                             flush on branch mispredict
// -----------------------------------------------------------------------------
interface inst_queue_if;
    logic        IF_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic        IF_queue_is_full;
    logic        ID_enable;
    logic        ID_queue_is_empty;
    logic [31:0] ID_inst;
    logic [31:0] ID_pc;
    logic        ROB_clear;

    modport master (
        output IF_valid, IF_inst, IF_pc, ID_enable, ROB_clear,
        input  IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc
    );

    modport slave (
        input  IF_valid, IF_inst, IF_pc, ID_enable, ROB_clear,
        output IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc
    );
endinterface

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Instruction FIFO between fetch and decode. Buffers instruction/PC pairs and
// presents the oldest one to decode combinationally from registered state, so
// decode can consume it in the same cycle. A ROB mispredict clear empties it.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset (clears pointers and count)
//   rdy  : global ready; when low all state is frozen
//   q    : inst_queue_if.slave (fetch push, decode pop, ROB clear, status)
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    inst_queue_if.slave   q
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ZERO_CNT = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ZERO_PTR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       inst_buf_q [DEPTH];
    logic [31:0]       pc_buf_q   [DEPTH];

    logic push_ok;
    logic pop_ok;
    logic empty;
    logic full;

    assign empty = (count_q == ZERO_CNT);
    assign full  = (count_q == FULL_CNT);

    // Next-state for pointers and count: freeze, flush, or push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        if (!rdy) begin
            // frozen: hold everything, no storage write
            head_d  = head_q;
            tail_d  = tail_q;
            count_d = count_q;
        end else if (q.ROB_clear) begin
            // flush wins over any push or pop in the same cycle
            head_d  = ZERO_PTR;
            tail_d  = ZERO_PTR;
            count_d = ZERO_CNT;
        end else begin
            push_ok = q.IF_valid & ~full;
            pop_ok  = q.ID_enable & ~empty;
            // power-of-two depth: pointer overflow is the wrap
            if (push_ok) begin
                tail_d = tail_q + ONE_PTR;
            end else begin
                tail_d = tail_q;
            end
            if (pop_ok) begin
                head_d = head_q + ONE_PTR;
            end else begin
                head_d = head_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= ZERO_PTR;
            tail_q  <= ZERO_PTR;
            count_q <= ZERO_CNT;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; not reset, only written on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            inst_buf_q[tail_q] <= q.IF_inst;
            pc_buf_q[tail_q]   <= q.IF_pc;
        end
    end

    // Head presentation depends on registered state only; zero when empty.
    assign q.IF_queue_is_full  = full;
    assign q.ID_queue_is_empty = empty;
    assign q.ID_inst           = empty ? 32'h0000_0000 : inst_buf_q[head_q];
    assign q.ID_pc             = empty ? 32'h0000_0000 : pc_buf_q[head_q];

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
// Directed bench for inst_queue: reset, basic push/pop, fill to full with a
// dropped push, steady simultaneous push/pop across pointer wrap, ROB flush,
// rdy freeze and asynchronous mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_inst_queue;

    logic clk;
    logic rst;
    logic rdy;
    int   n_checks;
    int   n_fail;

    inst_queue_if iq ();

    inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .q   (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle just after it
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        iq.IF_valid  = 1'b0;
        iq.IF_inst   = 32'h0;
        iq.IF_pc     = 32'h0;
        iq.ID_enable = 1'b0;
        iq.ROB_clear = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc);
        iq.IF_valid = 1'b1;
        iq.IF_pc    = pc;
        iq.IF_inst  = ~pc;
        step();
        iq.IF_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rdy = 1'b1;
        idle_inputs();
        #3;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", iq.ID_queue_is_empty); end
        n_checks++; if (iq.IF_queue_is_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", iq.IF_queue_is_full); end
        n_checks++; if (iq.ID_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", iq.ID_inst); end
        n_checks++; if (iq.ID_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", iq.ID_pc); end
        @(negedge clk);
        rst = 1'b1;
        step();
        // pop while empty must not underflow the count
        iq.ID_enable = 1'b1;
        step();
        iq.ID_enable = 1'b0;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty_empty got=%b exp=1", iq.ID_queue_is_empty); end
        n_checks++; if (iq.IF_queue_is_full !== 1'b0) begin n_fail++; $display("FAIL pop_empty_full got=%b exp=0", iq.IF_queue_is_full); end
    endtask

    task automatic test_push_pop;
        iq.IF_valid = 1'b1;
        iq.IF_inst  = 32'h0000_0013;
        iq.IF_pc    = 32'h0000_0000;
        // no bypass: before the edge the queue still reads empty
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL no_bypass got=%b exp=1", iq.ID_queue_is_empty); end
        step();
        n_checks++; if (iq.ID_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL first_inst got=%h exp=00000013", iq.ID_inst); end
        n_checks++; if (iq.ID_pc !== 32'h0) begin n_fail++; $display("FAIL first_pc got=%h exp=0", iq.ID_pc); end
        iq.IF_inst = 32'h0010_0093;
        iq.IF_pc   = 32'h0000_0004;
        step();
        iq.IF_valid  = 1'b0;
        n_checks++; if (iq.ID_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL head_kept got=%h exp=00000013", iq.ID_inst); end
        iq.ID_enable = 1'b1;
        step();
        n_checks++; if (iq.ID_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL second_inst got=%h exp=00100093", iq.ID_inst); end
        n_checks++; if (iq.ID_pc !== 32'h4) begin n_fail++; $display("FAIL second_pc got=%h exp=4", iq.ID_pc); end
        step();
        iq.ID_enable = 1'b0;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", iq.ID_queue_is_empty); end
        n_checks++; if (iq.ID_inst !== 32'h0) begin n_fail++; $display("FAIL drain_inst got=%h exp=0", iq.ID_inst); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            push_one(32'(i * 4));
            n_checks++; if (iq.IF_queue_is_full !== (i == 15)) begin n_fail++; $display("FAIL fill_full_%0d got=%b exp=%b", i, iq.IF_queue_is_full, (i == 15)); end
        end
        push_one(32'h0000_0040);
        n_checks++; if (iq.IF_queue_is_full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop got=%b exp=1", iq.IF_queue_is_full); end
        iq.ID_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (iq.ID_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL drain_pc_%0d got=%h exp=%h", i, iq.ID_pc, 32'(i * 4)); end
            step();
        end
        iq.ID_enable = 1'b0;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained got=%b exp=1", iq.ID_queue_is_empty); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] model [$];
        logic [31:0] next_pc;
        next_pc = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            push_one(next_pc);
            model.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
        iq.IF_valid  = 1'b1;
        iq.ID_enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            iq.IF_pc   = next_pc;
            iq.IF_inst = ~next_pc;
            n_checks++; if (iq.ID_pc !== model[0]) begin n_fail++; $display("FAIL b2b_pc_%0d got=%h exp=%h", c, iq.ID_pc, model[0]); end
            n_checks++; if (iq.ID_inst !== ~model[0]) begin n_fail++; $display("FAIL b2b_inst_%0d got=%h exp=%h", c, iq.ID_inst, ~model[0]); end
            step();
            void'(model.pop_front());
            model.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
        iq.IF_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (iq.ID_pc !== model[0]) begin n_fail++; $display("FAIL b2b_drain_%0d got=%h exp=%h", i, iq.ID_pc, model[0]); end
            step();
            void'(model.pop_front());
        end
        iq.ID_enable = 1'b0;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_count5 got=%b exp=1", iq.ID_queue_is_empty); end
    endtask

    task automatic test_clear;
        for (int i = 0; i < 10; i++) begin
            push_one(32'h0000_0400 + 32'(i * 4));
        end
        iq.ROB_clear = 1'b1;
        iq.IF_valid  = 1'b1;
        iq.IF_pc     = 32'h0000_0999;
        iq.ID_enable = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL clear_empty got=%b exp=1", iq.ID_queue_is_empty); end
        n_checks++; if (iq.ID_pc !== 32'h0) begin n_fail++; $display("FAIL clear_pc got=%h exp=0", iq.ID_pc); end
        push_one(32'h0000_0100);
        n_checks++; if (iq.ID_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL clear_refill got=%h exp=100", iq.ID_pc); end
        iq.ID_enable = 1'b1;
        step();
        iq.ID_enable = 1'b0;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL clear_single got=%b exp=1", iq.ID_queue_is_empty); end
    endtask

    task automatic test_rdy_and_async_reset;
        push_one(32'h0000_0300);
        push_one(32'h0000_0304);
        push_one(32'h0000_0308);
        rdy          = 1'b0;
        iq.IF_valid  = 1'b1;
        iq.IF_pc     = 32'h0000_03FC;
        iq.ID_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (iq.ID_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL freeze_pc_%0d got=%h exp=300", i, iq.ID_pc); end
        end
        rdy         = 1'b1;
        iq.IF_valid = 1'b0;
        step();
        n_checks++; if (iq.ID_pc !== 32'h0000_0304) begin n_fail++; $display("FAIL thaw_pc1 got=%h exp=304", iq.ID_pc); end
        step();
        n_checks++; if (iq.ID_pc !== 32'h0000_0308) begin n_fail++; $display("FAIL thaw_pc2 got=%h exp=308", iq.ID_pc); end
        step();
        iq.ID_enable = 1'b0;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL freeze_count got=%b exp=1", iq.ID_queue_is_empty); end
        push_one(32'h0000_0500);
        n_checks++; if (iq.ID_queue_is_empty !== 1'b0) begin n_fail++; $display("FAIL pre_reset got=%b exp=0", iq.ID_queue_is_empty); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL async_empty got=%b exp=1", iq.ID_queue_is_empty); end
        n_checks++; if (iq.ID_pc !== 32'h0) begin n_fail++; $display("FAIL async_pc got=%h exp=0", iq.ID_pc); end
        n_checks++; if (iq.ID_inst !== 32'h0) begin n_fail++; $display("FAIL async_inst got=%h exp=0", iq.ID_inst); end
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        n_checks++; if (iq.ID_queue_is_empty !== 1'b1) begin n_fail++; $display("FAIL post_reset got=%b exp=1", iq.ID_queue_is_empty); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_push_pop();
        test_fill();
        test_back_to_back();
        test_clear();
        test_rdy_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction FIFO between the fetch stage and the decode stage. It buffers fetched instruction/PC pairs and presents the oldest entry to decode combinationally, so decode can consume it in the same cycle. It pops when decode asserts its enable, and is flushed completely on a branch-mispredict clear from the ROB.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; one clock domain.
- rdy  input  1  global ready; when 0, all state is frozen. Reset still acts.
- IF_valid  input  1  fetch presents a new instruction this cycle.
- IF_inst  input  32  fetched instruction word.
- IF_pc  input  32  PC of the fetched instruction.
- IF_queue_is_full  output  1  1 when count == DEPTH; fetch must not push.
- ID_enable  input  1  decode consumes the head entry this cycle.
- ID_queue_is_empty  output  1  1 when count == 0 (IQEmpty encoding = 1).
- ID_inst  output  32  head instruction; 0 when empty.
- ID_pc  output  32  head PC; 0 when empty.
- ROB_clear  input  1  flush request from the ROB on mispredict.

## Operation
- State:
  - head pointer, ADDR_W bits;
  - tail pointer, ADDR_W bits;
  - count, ADDR_W+1 bits;
  - storage arrays inst_buf[DEPTH], pc_buf[DEPTH]. Storage is not reset.
- Reset (rst = 0, asynchronous): head = 0, tail = 0, count = 0. Resulting outputs: IF_queue_is_full = 0, ID_queue_is_empty = 1, ID_inst = 0, ID_pc = 0.
- Each rising edge with rst = 1 and rdy = 1 is evaluated in this priority order:
  1. ROB_clear = 1: head = tail = count = 0. Any push or pop in the same cycle is discarded.
  2. Otherwise compute two qualified strobes:
     - push_ok = IF_valid & (count != DEPTH)
     - pop_ok = ID_enable & (count != 0)
  3. push_ok: write inst_buf[tail] and pc_buf[tail]; tail = tail + 1, wrapping modulo DEPTH.
  4. pop_ok: head = head + 1, wrapping modulo DEPTH.
  5. count update: count + push_ok - pop_ok. Push and pop in the same cycle leave count unchanged.
- rdy = 0: no pointer, count or storage update. Outputs continue to reflect the held state.
- Push while full is silently dropped; fetch is responsible for honouring IF_queue_is_full.
- Pop while empty is ignored.
- No bypass: an entry pushed into an empty queue becomes visible at the head one cycle after the push edge.
- Push and pop in the same cycle are both legal at any 0 < count < DEPTH.
  - At count == DEPTH, only the pop takes effect (full was already asserted, so the push is rejected).
  - At count == 0, only the push takes effect.
- Outputs are combinational from registered state only; no input-to-output combinational path:
  - ID_inst = empty ? 0 : inst_buf[head]
  - ID_pc = empty ? 0 : pc_buf[head]

## Timing
- Push-to-head-visible latency: 1 cycle into an empty queue.
- Pop takes effect at the edge where ID_enable = 1 is sampled. The next entry appears in the following cycle.
- ID_queue_is_empty and IF_queue_is_full update in the cycle after the edge that changes count.
- ROB_clear: the queue reads empty in the cycle after the clear edge. A fetch asserted in that cycle is accepted normally.
- Pointer wrap: tail and head wrap from DEPTH-1 to 0 with no bubble.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously) and remain there until the first edge with rst = 1.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then idle → ID_queue_is_empty = 1, IF_queue_is_full = 0, ID_inst = 0, ID_pc = 0. An ID_enable pulse while empty leaves count = 0.
- Push 0x00000013 @ pc 0x0, then 0x00100093 @ pc 0x4 → after the first edge, ID_inst = 0x00000013 and ID_pc = 0x0. Pop → ID_inst = 0x00100093, ID_pc = 0x4. Pop → empty = 1.
- Push 16 entries (pc 0x0..0x3C) → full = 1. Push pc 0x40 → dropped. Pop all 16 → pcs read out 0x0..0x3C in order, then empty = 1.
- Steady state with 5 entries, simultaneous push and pop for 40 cycles → count stays 5. Pointers wrap twice. PC sequence is preserved, no loss or duplication.
- 10 entries present, assert ROB_clear together with IF_valid and ID_enable → next cycle empty = 1, count = 0. Push pc 0x100 → head pc = 0x100.
- rdy = 0 for 3 cycles with IF_valid and ID_enable held high → no change in count or head. Then drive rst = 0 mid-cycle → ID_queue_is_empty = 1 immediately, before any clock edge.
